// File: rtl/if_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_fetch_unit : PC owner, one-outstanding instruction fetch into the  |
// |                 IF/ID buffer with jump redirect.     Rev 1.0          |
// +----------------------------------------------------------------------+
module if_fetch_unit #(
  parameter int unsigned          AddrWidth = 64,
  parameter int unsigned          InstWidth = 32,
  parameter logic [AddrWidth-1:0] ResetPc   = AddrWidth'('h8000_0000)
) (
  input  logic                           Clk,
  input  logic                           Rst,
  output logic                           ReqValid,
  output logic [AddrWidth-1:0]           ReqAddr,
  input  logic                           ReqReady,
  input  logic                           RspValid,
  input  logic [InstWidth-1:0]           RspInst,
  input  logic                           JumpValid,
  input  logic [AddrWidth-1:0]           JumpAddr,
  input  logic                           BufFull,
  output logic                           BufWInc,
  output logic [AddrWidth+InstWidth-1:0] BufWData,
  output logic [AddrWidth-1:0]           Pc
);

  localparam int unsigned PktWidth = AddrWidth + InstWidth;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_REQ  = 3'd1,
    S_WAIT = 3'd2,
    S_HOLD = 3'd3,
    S_DROP = 3'd4
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [AddrWidth-1:0]  r_pc, w_pc_nxt;
  logic [PktWidth-1:0]   r_hold, w_hold_nxt;
  logic                  r_pend, w_pend_nxt;
  logic [AddrWidth-1:0]  w_jump_pc;
  logic [AddrWidth-1:0]  w_pc_inc;

  assign w_jump_pc = {JumpAddr[AddrWidth-1:2], 2'b00};
  assign w_pc_inc  = r_pc + AddrWidth'(4);
  assign ReqAddr   = r_pc;
  assign Pc        = r_pc;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      r_state <= S_IDLE;
      r_pc    <= ResetPc;
      r_hold  <= '0;
      r_pend  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_pc    <= w_pc_nxt;
      r_hold  <= w_hold_nxt;
      r_pend  <= w_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_hold_nxt  = r_hold;
    w_pend_nxt  = r_pend;
    ReqValid    = 1'b0;
    BufWInc     = 1'b0;
    BufWData    = '0;
    case (r_state)
      S_IDLE: begin
        w_state_nxt = S_REQ;
        if (JumpValid) w_pc_nxt = w_jump_pc;
      end
      S_REQ: begin
        ReqValid = 1'b1;
        if (JumpValid) begin
          w_pc_nxt = w_jump_pc;
          if (ReqReady) begin
            w_state_nxt = S_DROP;
            w_pend_nxt  = 1'b1;
          end
        end else if (ReqReady) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (JumpValid) begin
          w_pc_nxt = w_jump_pc;
          if (RspValid) begin
            w_state_nxt = S_REQ;
          end else begin
            w_state_nxt = S_DROP;
            w_pend_nxt  = 1'b1;
          end
        end else if (RspValid) begin
          w_pc_nxt = w_pc_inc;
          if (BufFull) begin
            w_hold_nxt  = {r_pc, RspInst};
            w_state_nxt = S_HOLD;
          end else begin
            BufWInc     = 1'b1;
            BufWData    = {r_pc, RspInst};
            w_state_nxt = S_REQ;
          end
        end
      end
      S_HOLD: begin
        BufWData = r_hold;
        if (JumpValid) begin
          w_pc_nxt    = w_jump_pc;
          w_hold_nxt  = '0;
          w_state_nxt = S_REQ;
        end else if (!BufFull) begin
          BufWInc     = 1'b1;
          w_hold_nxt  = '0;
          w_state_nxt = S_REQ;
        end
      end
      S_DROP: begin
        // Stay until the stale response is swallowed so it can never be taken for a new fetch
        if (RspValid) w_pend_nxt = 1'b0;
        if (JumpValid) begin
          w_pc_nxt = w_jump_pc;
        end else if (RspValid || !r_pend) begin
          w_state_nxt = S_REQ;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
`default_nettype none
// tb_if_fetch_unit : directed scenarios plus randomized traffic checked against
// an address-sequence model of the fetch stream.
module tb_if_fetch_unit;

  localparam logic [63:0] RPC = 64'h8000_0000;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        ReqValid;
  logic [63:0] ReqAddr;
  logic        ReqReady;
  logic        RspValid;
  logic [31:0] RspInst;
  logic        JumpValid;
  logic [63:0] JumpAddr;
  logic        BufFull;
  logic        BufWInc;
  logic [95:0] BufWData;
  logic [63:0] Pc;

  if_fetch_unit #(.AddrWidth(64), .InstWidth(32), .ResetPc(64'h8000_0000)) dut (
    .Clk(Clk), .Rst(Rst),
    .ReqValid(ReqValid), .ReqAddr(ReqAddr), .ReqReady(ReqReady),
    .RspValid(RspValid), .RspInst(RspInst),
    .JumpValid(JumpValid), .JumpAddr(JumpAddr),
    .BufFull(BufFull), .BufWInc(BufWInc), .BufWData(BufWData),
    .Pc(Pc)
  );

  always #5 Clk = ~Clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int lat     = 1;
  int viol    = 0;

  logic [63:0] mem_addr_q[$];
  int          mem_due_q[$];
  logic [95:0] push_act_q[$];
  logic [95:0] push_exp_q[$];
  int          push_cyc_q[$];
  logic [63:0] req_act_q[$];
  logic [63:0] req_exp_q[$];
  logic [63:0] exp_req;
  logic [63:0] exp_push;

  // Memory content is a fixed function of the address.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return (a[31:0] * 32'h9E37_79B1) ^ a[63:32] ^ 32'h0BAD_F00D;
  endfunction

  // One clock cycle: drive at negedge, observe 1ns later, advance to next negedge.
  // Accepted addresses and pushed pcs must each run +4 from the last jump target.
  task automatic step(input logic jv, input logic [63:0] ja, input logic full, input logic rdy);
    JumpValid = jv; JumpAddr = ja; BufFull = full; ReqReady = rdy;
    if (mem_due_q.size() != 0 && mem_due_q[0] <= cyc) begin
      RspValid = 1'b1;
      RspInst  = mem_word(mem_addr_q[0]);
      void'(mem_addr_q.pop_front());
      void'(mem_due_q.pop_front());
    end else begin
      RspValid = 1'b0;
      RspInst  = $urandom;
    end
    #1;
    if (ReqValid && ReqReady) begin
      if (ReqAddr[1:0] != 2'b00 || mem_due_q.size() != 0) viol++;
      req_act_q.push_back(ReqAddr);
      req_exp_q.push_back(exp_req);
      exp_req += 64'd4;
      mem_addr_q.push_back(ReqAddr);
      mem_due_q.push_back(cyc + lat);
    end
    if (BufWInc) begin
      if (jv || full) viol++;
      push_act_q.push_back(BufWData);
      push_exp_q.push_back({exp_push, mem_word(exp_push)});
      push_cyc_q.push_back(cyc);
      exp_push += 64'd4;
    end
    if (jv) begin
      exp_req  = {ja[63:2], 2'b00};
      exp_push = {ja[63:2], 2'b00};
    end
    @(negedge Clk);
    cyc++;
  endtask

  task automatic reset_dut();
    Rst = 1'b0; ReqReady = 1'b0; RspValid = 1'b0; RspInst = '0;
    JumpValid = 1'b0; JumpAddr = '0; BufFull = 1'b0;
    mem_addr_q.delete(); mem_due_q.delete();
    push_act_q.delete(); push_exp_q.delete(); push_cyc_q.delete();
    req_act_q.delete(); req_exp_q.delete();
    viol = 0; lat = 1; exp_req = RPC; exp_push = RPC;
    repeat (2) @(negedge Clk);
    Rst = 1'b1;
  endtask

  task automatic test_reset();
    reset_dut();
    Rst = 1'b0;
    @(negedge Clk); #1;
    n_tests++; if (ReqValid !== 1'b0) begin n_fail++; $display("FAIL reset_reqvalid: got %b want 0", ReqValid); end
    n_tests++; if (ReqAddr !== RPC) begin n_fail++; $display("FAIL reset_reqaddr: got %h want %h", ReqAddr, RPC); end
    n_tests++; if (Pc !== RPC) begin n_fail++; $display("FAIL reset_pc: got %h want %h", Pc, RPC); end
    n_tests++; if (BufWInc !== 1'b0 || BufWData !== 96'd0) begin n_fail++; $display("FAIL reset_buf: got inc=%b data=%h want 0/0", BufWInc, BufWData); end
    @(negedge Clk);
    Rst = 1'b1; ReqReady = 1'b1;
    #1;
    n_tests++; if (ReqValid !== 1'b0) begin n_fail++; $display("FAIL release_idle: got ReqValid=%b want 0", ReqValid); end
    @(negedge Clk);
    n_tests++; if (ReqValid !== 1'b1 || ReqAddr !== RPC) begin n_fail++; $display("FAIL release_req: got v=%b a=%h want 1/%h", ReqValid, ReqAddr, RPC); end
  endtask

  task automatic test_sequential();
    reset_dut();
    repeat (7) step(1'b0, 64'd0, 1'b0, 1'b1);
    n_tests++;
    if (push_act_q.size() != 3) begin
      n_fail++; $display("FAIL seq_count: got %0d pushes want 3", push_act_q.size());
    end else begin
      for (int k = 0; k < 3; k++) begin
        logic [63:0] a;
        a = RPC + 64'(4 * k);
        n_tests++;
        if (push_act_q[k] !== {a, mem_word(a)}) begin n_fail++; $display("FAIL seq_push%0d: got %h want %h", k, push_act_q[k], {a, mem_word(a)}); end
      end
      n_tests++;
      if (push_cyc_q[1] - push_cyc_q[0] != 2 || push_cyc_q[2] - push_cyc_q[1] != 2) begin
        n_fail++; $display("FAIL seq_gap: got gaps %0d,%0d want 2,2", push_cyc_q[1] - push_cyc_q[0], push_cyc_q[2] - push_cyc_q[1]);
      end
    end
    n_tests++; if (viol !== 0) begin n_fail++; $display("FAIL seq_protocol: got %0d violations want 0", viol); end
  endtask

  task automatic test_backpressure();
    reset_dut();
    repeat (4) step(1'b0, 64'd0, 1'b0, 1'b1);
    repeat (4) step(1'b0, 64'd0, 1'b1, 1'b1);
    n_tests++; if (push_act_q.size() != 1 || req_act_q.size() != 2) begin
      n_fail++; $display("FAIL bp_stall: got pushes=%0d reqs=%0d want 1/2", push_act_q.size(), req_act_q.size()); end
    step(1'b0, 64'd0, 1'b0, 1'b1);
    n_tests++; if (push_act_q.size() != 2 || push_act_q[push_act_q.size()-1] !== {RPC + 64'd4, mem_word(RPC + 64'd4)}) begin
      n_fail++; $display("FAIL bp_release: got n=%0d last=%h want 2/%h", push_act_q.size(), push_act_q[push_act_q.size()-1], {RPC + 64'd4, mem_word(RPC + 64'd4)}); end
    step(1'b0, 64'd0, 1'b0, 1'b1);
    n_tests++; if (req_act_q.size() != 3 || req_act_q[req_act_q.size()-1] !== RPC + 64'd8) begin
      n_fail++; $display("FAIL bp_next_req: got n=%0d addr=%h want 3/%h", req_act_q.size(), req_act_q[req_act_q.size()-1], RPC + 64'd8); end
    n_tests++; if (viol !== 0) begin n_fail++; $display("FAIL bp_protocol: got %0d violations want 0", viol); end
  endtask

  task automatic test_jump_wait();
    int stale;
    reset_dut();
    lat = 3;
    repeat (2) step(1'b0, 64'd0, 1'b0, 1'b1);
    lat = 1;
    step(1'b1, 64'h8000_0103, 1'b0, 1'b1);
    repeat (6) step(1'b0, 64'd0, 1'b0, 1'b1);
    stale = 0;
    foreach (push_act_q[k]) if (push_act_q[k][95:32] == RPC) stale++;
    n_tests++; if (stale != 0) begin n_fail++; $display("FAIL jw_stale: got %0d stale pushes want 0", stale); end
    n_tests++; if (req_act_q.size() < 2 || req_act_q[1] !== 64'h8000_0100) begin
      n_fail++; $display("FAIL jw_req: got n=%0d addr=%h want >=2/%h", req_act_q.size(), req_act_q[req_act_q.size()-1], 64'h8000_0100); end
    n_tests++; if (push_act_q.size() < 1 || push_act_q[0] !== {64'h8000_0100, mem_word(64'h8000_0100)}) begin
      n_fail++; $display("FAIL jw_push: got n=%0d first=%h want %h", push_act_q.size(), push_act_q[0], {64'h8000_0100, mem_word(64'h8000_0100)}); end
  endtask

  task automatic test_jump_hold();
    int stale;
    reset_dut();
    repeat (4) step(1'b0, 64'd0, 1'b0, 1'b1);
    step(1'b0, 64'd0, 1'b1, 1'b1);
    step(1'b1, 64'h9000_0000, 1'b1, 1'b1);
    repeat (5) step(1'b0, 64'd0, 1'b0, 1'b1);
    stale = 0;
    foreach (push_act_q[k]) if (push_act_q[k][95:32] == RPC + 64'd4) stale++;
    n_tests++; if (stale != 0) begin n_fail++; $display("FAIL jh_stale: got %0d held pushes want 0", stale); end
    n_tests++; if (push_act_q.size() != 3 || push_act_q[1] !== {64'h9000_0000, mem_word(64'h9000_0000)}) begin
      n_fail++; $display("FAIL jh_resume: got n=%0d p1=%h want 3/%h", push_act_q.size(), push_act_q[1], {64'h9000_0000, mem_word(64'h9000_0000)}); end
    n_tests++; if (viol !== 0) begin n_fail++; $display("FAIL jh_protocol: got %0d violations want 0", viol); end
  endtask

  task automatic test_jump_accept();
    reset_dut();
    step(1'b0, 64'd0, 1'b0, 1'b1);
    step(1'b1, 64'hA000_0012, 1'b0, 1'b1);
    repeat (6) step(1'b0, 64'd0, 1'b0, 1'b1);
    n_tests++; if (req_act_q.size() < 2 || req_act_q[0] !== RPC || req_act_q[1] !== 64'hA000_0010) begin
      n_fail++; $display("FAIL ja_req: got n=%0d r0=%h r1=%h want %h/%h", req_act_q.size(), req_act_q[0], req_act_q[1], RPC, 64'hA000_0010); end
    n_tests++; if (push_act_q.size() < 1 || push_act_q[0] !== {64'hA000_0010, mem_word(64'hA000_0010)}) begin
      n_fail++; $display("FAIL ja_push: got n=%0d first=%h want %h", push_act_q.size(), push_act_q[0], {64'hA000_0010, mem_word(64'hA000_0010)}); end
    n_tests++; if (viol !== 0) begin n_fail++; $display("FAIL ja_protocol: got %0d violations want 0", viol); end
  endtask

  task automatic test_wrap();
    reset_dut();
    step(1'b0, 64'd0, 1'b0, 1'b0);
    step(1'b1, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0);
    repeat (5) step(1'b0, 64'd0, 1'b0, 1'b1);
    n_tests++; if (push_act_q.size() != 2 || push_act_q[0] !== {64'hFFFF_FFFF_FFFF_FFFC, mem_word(64'hFFFF_FFFF_FFFF_FFFC)}) begin
      n_fail++; $display("FAIL wrap_top: got n=%0d p0=%h want 2/%h", push_act_q.size(), push_act_q[0], {64'hFFFF_FFFF_FFFF_FFFC, mem_word(64'hFFFF_FFFF_FFFF_FFFC)}); end
    n_tests++; if (push_act_q.size() != 2 || push_act_q[1] !== {64'd0, mem_word(64'd0)}) begin
      n_fail++; $display("FAIL wrap_zero: got p1=%h want %h", push_act_q[push_act_q.size()-1], {64'd0, mem_word(64'd0)}); end
    n_tests++; if (req_act_q.size() != 3 || req_act_q[1] !== 64'd0) begin
      n_fail++; $display("FAIL wrap_req: got n=%0d r1=%h want 3/0", req_act_q.size(), req_act_q[1]); end
  endtask

  task automatic test_reset_midop();
    reset_dut();
    repeat (3) step(1'b0, 64'd0, 1'b0, 1'b1);
    lat = 3;
    repeat (2) step(1'b0, 64'd0, 1'b0, 1'b1);
    #2 Rst = 1'b0;
    #1;
    n_tests++; if (Pc !== RPC || ReqAddr !== RPC || ReqValid !== 1'b0) begin
      n_fail++; $display("FAIL midrst_pc: got pc=%h a=%h v=%b want %h/%h/0", Pc, ReqAddr, ReqValid, RPC, RPC); end
    n_tests++; if (BufWInc !== 1'b0 || BufWData !== 96'd0) begin
      n_fail++; $display("FAIL midrst_buf: got inc=%b data=%h want 0/0", BufWInc, BufWData); end
    reset_dut();
    repeat (3) step(1'b0, 64'd0, 1'b0, 1'b1);
    n_tests++; if (push_act_q.size() != 1 || push_act_q[0] !== {RPC, mem_word(RPC)}) begin
      n_fail++; $display("FAIL midrst_resume: got n=%0d p0=%h want 1/%h", push_act_q.size(), push_act_q[0], {RPC, mem_word(RPC)}); end
  endtask

  task automatic test_random();
    logic        full_r;
    logic        jv;
    logic [63:0] ja;
    int          bad;
    int          first;
    reset_dut();
    full_r = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 3) == 0) full_r = ~full_r;
      lat = int'($urandom_range(1, 3));
      jv  = (c != 0) && ($urandom_range(0, 24) == 0);
      ja  = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) ja = 64'hFFFF_FFFF_FFFF_FFF0 | 64'($urandom_range(0, 15));
      step(jv, ja, full_r, $urandom_range(0, 9) < 7);
    end
    bad = 0; first = 0;
    foreach (push_act_q[k]) if (push_act_q[k] !== push_exp_q[k]) begin if (bad == 0) first = k; bad++; end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rnd_push_stream: got %0d bad, first #%0d %h want %h", bad, first, push_act_q[first], push_exp_q[first]); end
    bad = 0; first = 0;
    foreach (req_act_q[k]) if (req_act_q[k] !== req_exp_q[k]) begin if (bad == 0) first = k; bad++; end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rnd_req_stream: got %0d bad, first #%0d %h want %h", bad, first, req_act_q[first], req_exp_q[first]); end
    n_tests++; if (push_act_q.size() < 100) begin n_fail++; $display("FAIL rnd_progress: got %0d pushes want >=100", push_act_q.size()); end
    n_tests++; if (viol !== 0) begin n_fail++; $display("FAIL rnd_protocol: got %0d violations want 0", viol); end
  endtask

  initial begin
    Rst = 1'b0; ReqReady = 1'b0; RspValid = 1'b0; RspInst = '0;
    JumpValid = 1'b0; JumpAddr = '0; BufFull = 1'b0;
    @(negedge Clk);
    test_reset();
    test_sequential();
    test_backpressure();
    test_jump_wait();
    test_jump_hold();
    test_jump_accept();
    test_wrap();
    test_reset_midop();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
